nucleic_acid_sequencer: RTL and testbench
=========================================

Name: nucleic_acid_sequencer

Overview:
- Clocked controller that drives every pneumatic control line of the 4-lane nucleic acid extraction chip.
- Drives the shared inlet valves, the per-lane valve groups and the three-valve peristaltic pump.
- Sits directly upstream of the valve network. Its outputs drive the off-chip solenoid bank that pressurises the air_in lines.
- Runs one protocol (lysis, mix, bead trap, wash, elute) per start request.

Parameters:
- FILL_CYC, 64, clocks the lysis inlet stays open (LYSIS_FILL).
- MIX_CYC, 8, full pump cycles (6 phases each) run in MIX.
- TRAP_CYC, 128, clocks in BEAD_TRAP.
- WASH_CYC, 256, clocks in WASH.
- ELUTE_CYC, 128, clocks in ELUTE.
- PUMP_DIV, 16, clocks per pump phase.
- CNT_W, 16, width of the duration and prescale counters. All durations must fit in CNT_W; a value of 0 is treated as 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  one-cycle request to run the protocol; honoured only in IDLE
- abort  input  1  level; forces return to IDLE
- busy  output  1  high in any state other than IDLE/DONE
- done  output  1  one-cycle pulse on protocol completion
- step  output  3  current state encoding (IDLE=0 … DONE=6)
- lysis_ctl, wash_ctl, elute_ctl  output  1 each  shared inlet valves
- horiz_ctl, vertical_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl  output  1 each  lane valve groups
- pump1, pump2, pump3  output  1 each  peristaltic pump valves

Behaviour:
- Valve polarity: ctl=1 means pressurised, i.e. valve closed; 0 means open.
- All outputs are registered.
- Reset values:
  - all valve ctl outputs = 1; {pump1,pump2,pump3} = 3'b111.
  - busy = 0, done = 0, step = 0 (IDLE); all counters = 0.
- Latency: start sampled high in IDLE at cycle N → state LYSIS_FILL, with its valve pattern visible on outputs at cycle N+1.
- States and open valves (every valve not listed is closed):
  - IDLE (0): none open; pumps 111.
  - LYSIS_FILL (1): lysis, vertical, horiz open; pumps 111; lasts FILL_CYC clocks.
  - MIX (2): none open; pump runs; lasts MIX_CYC×6×PUMP_DIV clocks.
  - BEAD_TRAP (3): bead_vtl, loop_exit, waste open; bead_trap closed; pump runs; lasts TRAP_CYC clocks.
  - WASH (4): wash, vertical, loop_exit, waste open; pump runs; lasts WASH_CYC clocks.
  - ELUTE (5): elute, vertical, loop_exit, bead_trap, collection open; pump runs; lasts ELUTE_CYC clocks.
  - DONE (6): none open; done=1 for exactly this one cycle; then IDLE.
- Duration counter: loads 0 on entry to each state; the state exits when counter == duration−1.
- Pump driver:
  - Phase sequence for {pump1,pump2,pump3}: 110, 100, 101, 001, 011, 010, then wraps to 110. Exactly one bit changes per phase.
  - The phase advances every PUMP_DIV clocks while the pump is enabled.
  - Phase 0 (110) appears on the first cycle of a pumping state.
  - When the pump is disabled, the output is 111 on the next cycle, and the phase and prescaler reset to 0.
  - Consecutive pumping states (MIX→BEAD_TRAP→…) do not restart the phase; the phase continues.
- start while busy: ignored, no queueing.
- abort, any state except IDLE:
  - next state IDLE; all valves closed and pumps 111 the following cycle.
  - done not pulsed.
- abort and start together in IDLE: abort wins; state stays IDLE.
- abort held high: start is blocked.
- Reset mid-protocol: immediate (asynchronous) return to reset values; no done.

Optional Feature:
- Macro: MIX_REVERSE_EN.
- Defined: in MIX, pump direction reverses after every completed pump cycle (sequence walked backwards: 110, 010, 011, …), for back-and-forth mixing. MIX duration is unchanged.
- Other pumping states always run forward, resuming from the current phase.
- Undefined: MIX always runs forward; the direction logic is absent.

Decomposition:
- Shared package nucleic_acid_pkg holds:
  - the state enum (3-bit values 0–6);
  - the 6-entry pump phase pattern constant array;
  - a valve-vector typedef: 10-bit packed struct in port order;
  - per-state open-valve mask constants.
- Natural sub-module: peristaltic_pump_driver, containing the prescaler, phase counter, enable and (optional) direction logic. It outputs the 3-bit pump vector and a cycle_done pulse.

Test Plan:
- Reset, then idle 20 clocks → all ctl=1, pumps=111, busy=0, step=0, done never high.
- FILL_CYC=4, MIX_CYC=1, TRAP/WASH/ELUTE=8, PUMP_DIV=2; pulse start at cycle 10:
  - step=1 on cycles 11–14;
  - MIX for 12 cycles (step=2) with pumps 110,110,100,100,…,010,010;
  - done high exactly at cycle 51.
- PUMP_DIV=3 in MIX: each pump pattern holds 3 clocks; exactly one pump bit toggles per phase change.
- abort asserted at cycle 3 of WASH → next cycle step=0, all ctl=1, pumps=111; done stays 0; a later start runs the full protocol normally.
- start pulsed during BEAD_TRAP → no effect, timing unchanged; start+abort together in IDLE → remains IDLE.
- MIX_REVERSE_EN defined, MIX_CYC=2 → second pump cycle shows 110,010,011,001,101,100; BEAD_TRAP resumes forward from the current phase.

Source files
------------

// File: rtl/nucleic_acid_sequencer_pkg.sv
// Shared types and constants for the nucleic acid extraction sequencer:
// state encoding, valve vector layout, per-state open masks and pump phase table.
package nucleic_acid_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LYSIS_FILL = 3'd1,
    S_MIX        = 3'd2,
    S_BEAD_TRAP  = 3'd3,
    S_WASH       = 3'd4,
    S_ELUTE      = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  // Port order; 1 = pressurised (closed)
  typedef struct packed {
    logic lysis;
    logic wash;
    logic elute;
    logic horiz;
    logic vertical;
    logic loop_exit;
    logic bead_vtl;
    logic bead_trap;
    logic collection;
    logic waste;
  } valve_t;

  localparam logic [2:0] PUMP_PAT [0:5] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
  localparam logic [2:0] PUMP_OFF = 3'b111;

  localparam valve_t OPEN_NONE  = '0;
  localparam valve_t OPEN_LYSIS = '{lysis: 1'b1, vertical: 1'b1, horiz: 1'b1, default: 1'b0};
  localparam valve_t OPEN_TRAP  = '{bead_vtl: 1'b1, loop_exit: 1'b1, waste: 1'b1, default: 1'b0};
  localparam valve_t OPEN_WASH  = '{wash: 1'b1, vertical: 1'b1, loop_exit: 1'b1, waste: 1'b1,
                                    default: 1'b0};
  localparam valve_t OPEN_ELUTE = '{elute: 1'b1, vertical: 1'b1, loop_exit: 1'b1,
                                    bead_trap: 1'b1, collection: 1'b1, default: 1'b0};

  function automatic int eff_len(input int v);
    return (v <= 0) ? 1 : v;
  endfunction

  function automatic valve_t open_mask(input state_t s);
    case (s)
      S_LYSIS_FILL: return OPEN_LYSIS;
      S_BEAD_TRAP:  return OPEN_TRAP;
      S_WASH:       return OPEN_WASH;
      S_ELUTE:      return OPEN_ELUTE;
      default:      return OPEN_NONE;
    endcase
  endfunction

  function automatic logic is_pumping(input state_t s);
    return (s == S_MIX) || (s == S_BEAD_TRAP) || (s == S_WASH) || (s == S_ELUTE);
  endfunction

endpackage

// File: rtl/nucleic_acid_sequencer_pump.sv
// Three-valve peristaltic pump driver: prescaler, 6-phase walker, enable handling.
// With MIX_REVERSE_EN defined, direction flips after each completed cycle while rev_en is high.
module peristaltic_pump_driver
  import nucleic_acid_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PUMP_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
`ifdef MIX_REVERSE_EN
  input  logic       rev_en,
`endif
  output logic [2:0] pump,
  output logic       cycle_done
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(eff_len(PUMP_DIV) - 1);

  logic [CNT_W-1:0] presc;
  logic [2:0]       phase;
  logic [2:0]       phase_adv;
  logic             active;
  logic             back;

`ifdef MIX_REVERSE_EN
  logic dir;
  assign back = dir & rev_en;
`else
  assign back = 1'b0;
`endif

  always_comb begin
    phase_adv = 3'd0;
    if (back) phase_adv = (phase == 3'd0) ? 3'd5 : phase - 3'd1;
    else      phase_adv = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
  end

  // High on the last clock of a full six-phase cycle
  assign cycle_done = active && (presc == DIV_LAST) && (phase_adv == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      phase  <= 3'd0;
      active <= 1'b0;
      pump   <= PUMP_OFF;
`ifdef MIX_REVERSE_EN
      dir    <= 1'b0;
`endif
    end else if (!en) begin
      presc  <= '0;
      phase  <= 3'd0;
      active <= 1'b0;
      pump   <= PUMP_OFF;
`ifdef MIX_REVERSE_EN
      dir    <= 1'b0;
`endif
    end else if (!active) begin
      active <= 1'b1;
      presc  <= '0;
      phase  <= 3'd0;
      pump   <= PUMP_PAT[0];
    end else if (presc == DIV_LAST) begin
      presc <= '0;
      phase <= phase_adv;
      pump  <= PUMP_PAT[phase_adv];
`ifdef MIX_REVERSE_EN
      if (cycle_done && rev_en) dir <= ~dir;
`endif
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/nucleic_acid_sequencer.sv
// Protocol sequencer for the 4-lane extraction chip: lysis, mix, bead trap, wash, elute.
// Optional MIX_REVERSE_EN build makes the pump alternate direction during MIX.
module nucleic_acid_sequencer
  import nucleic_acid_pkg::*;
#(
  parameter int FILL_CYC  = 64,
  parameter int MIX_CYC   = 8,
  parameter int TRAP_CYC  = 128,
  parameter int WASH_CYC  = 256,
  parameter int ELUTE_CYC = 128,
  parameter int PUMP_DIV  = 16,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [2:0] step,
  output logic       lysis_ctl,
  output logic       wash_ctl,
  output logic       elute_ctl,
  output logic       horiz_ctl,
  output logic       vertical_ctl,
  output logic       loop_exit_ctl,
  output logic       bead_vtl_ctl,
  output logic       bead_trap_ctl,
  output logic       collection_ctl,
  output logic       waste_ctl,
  output logic       pump1,
  output logic       pump2,
  output logic       pump3
);

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(eff_len(FILL_CYC) - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(eff_len(MIX_CYC) * 6 * eff_len(PUMP_DIV) - 1);
  localparam logic [CNT_W-1:0] TRAP_LAST  = CNT_W'(eff_len(TRAP_CYC) - 1);
  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(eff_len(WASH_CYC) - 1);
  localparam logic [CNT_W-1:0] ELUTE_LAST = CNT_W'(eff_len(ELUTE_CYC) - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  valve_t           ctl_q;
  logic [2:0]       pump_vec;
  logic             pump_wrap;

  // MIX length is a whole number of pump cycles, so the wrap coincides with the count
  function automatic state_t next_state(input state_t s, input logic [CNT_W-1:0] c,
                                        input logic st, input logic ab, input logic wrap);
    if (ab) return S_IDLE;
    case (s)
      S_IDLE:       return st ? S_LYSIS_FILL : S_IDLE;
      S_LYSIS_FILL: return (c == FILL_LAST) ? S_MIX : S_LYSIS_FILL;
      S_MIX:        return (c == MIX_LAST && wrap) ? S_BEAD_TRAP : S_MIX;
      S_BEAD_TRAP:  return (c == TRAP_LAST) ? S_WASH : S_BEAD_TRAP;
      S_WASH:       return (c == WASH_LAST) ? S_ELUTE : S_WASH;
      S_ELUTE:      return (c == ELUTE_LAST) ? S_DONE : S_ELUTE;
      default:      return S_IDLE;
    endcase
  endfunction

  assign state_nxt = next_state(state, cnt, start, abort, pump_wrap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ctl_q <= '1;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state || state_nxt == S_IDLE) ? '0 : cnt + 1'b1;
      busy  <= !(state_nxt inside {S_IDLE, S_DONE});
      done  <= (state_nxt == S_DONE);
      ctl_q <= valve_t'(~open_mask(state_nxt));
    end
  end

  peristaltic_pump_driver #(
    .CNT_W    (CNT_W),
    .PUMP_DIV (PUMP_DIV)
  ) u_pump (
    .clk        (clk),
    .rst        (rst),
    .en         (is_pumping(state_nxt)),
`ifdef MIX_REVERSE_EN
    .rev_en     (state == S_MIX),
`endif
    .pump       (pump_vec),
    .cycle_done (pump_wrap)
  );

  assign step           = state;
  assign lysis_ctl      = ctl_q.lysis;
  assign wash_ctl       = ctl_q.wash;
  assign elute_ctl      = ctl_q.elute;
  assign horiz_ctl      = ctl_q.horiz;
  assign vertical_ctl   = ctl_q.vertical;
  assign loop_exit_ctl  = ctl_q.loop_exit;
  assign bead_vtl_ctl   = ctl_q.bead_vtl;
  assign bead_trap_ctl  = ctl_q.bead_trap;
  assign collection_ctl = ctl_q.collection;
  assign waste_ctl      = ctl_q.waste;
  assign {pump1, pump2, pump3} = pump_vec;

endmodule

// File: tb/tb_nucleic_acid_sequencer.sv
// Scoreboard bench for nucleic_acid_sequencer: a driver pushes the expected per-cycle
// output frame from a protocol-level model, a monitor pops and compares every cycle.
module tb_nucleic_acid_sequencer;

  localparam int FILL  = 4;
  localparam int MIXC  = 2;
  localparam int TRAP  = 8;
  localparam int WASH  = 8;
  localparam int ELUTE = 8;
  localparam int DIV   = 2;

  // frame = {busy, done, step[2:0], ctl[9:0] (lysis..waste), pump[2:0]}
  typedef logic [17:0] frame_t;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic busy, done;
  logic [2:0] step;
  logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl;
  logic bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl;
  logic pump1, pump2, pump3;

  always #5 clk = ~clk;

  nucleic_acid_sequencer #(
    .FILL_CYC(FILL), .MIX_CYC(MIXC), .TRAP_CYC(TRAP), .WASH_CYC(WASH),
    .ELUTE_CYC(ELUTE), .PUMP_DIV(DIV), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .step(step),
    .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
    .horiz_ctl(horiz_ctl), .vertical_ctl(vertical_ctl), .loop_exit_ctl(loop_exit_ctl),
    .bead_vtl_ctl(bead_vtl_ctl), .bead_trap_ctl(bead_trap_ctl),
    .collection_ctl(collection_ctl), .waste_ctl(waste_ctl),
    .pump1(pump1), .pump2(pump2), .pump3(pump3)
  );

  // open-valve bit positions within the 10-bit ctl field
  localparam int LY = 9, WA = 8, EL = 7, HO = 6, VE = 5, LE = 4, BV = 3, BT = 2, CO = 1, WS = 0;

  logic [2:0] pat [6];
  frame_t plan[$];
  frame_t exp_q[$];
  frame_t last_exp;
  frame_t idle_f;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic frame_t mk(input int st, input logic [9:0] open, input logic [2:0] pmp);
    logic b, d;
    b = (st >= 1 && st <= 5);
    d = (st == 6);
    return {b, d, 3'(st), ~open, pmp};
  endfunction

  function automatic logic [9:0] bits(input int a, input int b, input int c,
                                      input int d, input int e);
    logic [9:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    if (e >= 0) v[e] = 1'b1;
    return v;
  endfunction

  function automatic frame_t actual();
    return {busy, done, step, lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
            loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl,
            pump1, pump2, pump3};
  endfunction

  task automatic check(input string name, input frame_t got, input frame_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got busy=%b done=%b step=%0d ctl=%b pump=%b, expected busy=%b done=%b step=%0d ctl=%b pump=%b",
               name, $time, got[17], got[16], got[15:13], got[12:3], got[2:0],
               want[17], want[16], want[15:13], want[12:3], want[2:0]);
    end
  endtask

  // Whole-protocol expectation: one frame per clock from the first LYSIS cycle to DONE.
  task automatic build_plan();
    int t, idx, pos, cyc;
    plan.delete();
    for (int i = 0; i < FILL; i++) plan.push_back(mk(1, bits(LY, VE, HO, -1, -1), 3'b111));
    for (int k = 0; k < MIXC * 6 * DIV; k++) begin
      cyc = k / (6 * DIV);
      pos = (k / DIV) % 6;
      idx = pos;
`ifdef MIX_REVERSE_EN
      if (cyc % 2 == 1) idx = (6 - pos) % 6;
`endif
      plan.push_back(mk(2, '0, pat[idx]));
    end
    t = 0;
    for (int i = 0; i < TRAP; i++) begin
      plan.push_back(mk(3, bits(BV, LE, WS, -1, -1), pat[(t / DIV) % 6])); t++;
    end
    for (int i = 0; i < WASH; i++) begin
      plan.push_back(mk(4, bits(WA, VE, LE, WS, -1), pat[(t / DIV) % 6])); t++;
    end
    for (int i = 0; i < ELUTE; i++) begin
      plan.push_back(mk(5, bits(EL, VE, LE, BT, CO), pat[(t / DIV) % 6])); t++;
    end
    plan.push_back(mk(6, '0, 3'b111));
  endtask

  task automatic drive(input logic st, input logic ab);
    frame_t e;
    @(negedge clk);
    start = st;
    abort = ab;
    if (ab) begin
      plan.delete();
      e = idle_f;
    end else if (plan.size() > 0) begin
      e = plan.pop_front();
    end else if (last_exp[15:13] == 3'd0 && st) begin
      build_plan();
      e = plan.pop_front();
    end else begin
      e = idle_f;
    end
    last_exp = e;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    frame_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("frame", actual(), e);
      end
    end
  end

  initial begin : stim
    int hold;
    logic st, ab;
    pat[0] = 3'b110; pat[1] = 3'b100; pat[2] = 3'b101;
    pat[3] = 3'b001; pat[4] = 3'b011; pat[5] = 3'b010;
    idle_f = mk(0, '0, 3'b111);
    last_exp = idle_f;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    #12;
    check("reset_values", actual(), idle_f);
    @(negedge clk);
    rst = 1'b0;

    repeat (20) drive(1'b0, 1'b0);

    // full protocol
    drive(1'b1, 1'b0);
    repeat (60) drive(1'b0, 1'b0);

    // start pulsed during BEAD_TRAP is ignored
    drive(1'b1, 1'b0);
    repeat (29) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (30) drive(1'b0, 1'b0);

    // start+abort together in IDLE
    drive(1'b1, 1'b1);
    repeat (5) drive(1'b0, 1'b0);

    // abort on third WASH cycle, then a clean run
    drive(1'b1, 1'b0);
    repeat (38) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    repeat (5) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (60) drive(1'b0, 1'b0);

    // randomized start/abort traffic, including held aborts
    hold = 0;
    repeat (3000) begin
      st = ($urandom_range(0, 99) < 8);
      if (hold > 0) hold--;
      else if ($urandom_range(0, 299) < 2) hold = $urandom_range(0, 4);
      ab = (hold > 0) || ($urandom_range(0, 499) == 0);
      drive(st, ab);
    end
    repeat (60) drive(1'b0, 1'b0);

    // asynchronous reset mid-protocol
    drive(1'b1, 1'b0);
    repeat (20) drive(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset", actual(), idle_f);
    plan.delete();
    last_exp = idle_f;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    repeat (60) drive(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d frames left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
